// File: rtl/joybus_frame_tx.sv
// joybus_frame_tx: serialises a streamed byte frame onto the Joybus line
// using the 4-level bit code (0 = L,L,L,H; 1 = L,H,H,H), then appends a
// controller (L,L,H,H) or console (L,H,H,H) stop bit.
// Ports:
//   sample_clk, reset   clock and synchronous active-high reset
//   start, byte_count   begin a frame of byte_count bytes (sampled in IDLE)
//   stop_mode           0 = controller stop, 1 = console stop (latched with start)
//   byte_data/valid     streamed payload, MSB first; byte_ready accepts it
//   data_tx             registered line level, idle high
//   busy, done          frame in progress; one-cycle pulse after the stop bit
//   underrun            one-cycle pulse when the stream ran dry mid-frame
module joybus_frame_tx #(
    parameter int LEVEL_WIDTH = 2,
    parameter int LEN_WIDTH   = 6
) (
    input  logic                 sample_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] byte_count,
    input  logic                 stop_mode,
    input  logic [7:0]           byte_data,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 data_tx,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);
    localparam int BW  = 4 * LEVEL_WIDTH;
    localparam int LVW = $clog2(BW);
    localparam logic [LVW-1:0] LAST = LVW'(BW - 1);
    localparam logic [LVW-1:0] Q1   = LVW'(LEVEL_WIDTH);
    localparam logic [LVW-1:0] Q2   = LVW'(2 * LEVEL_WIDTH);
    localparam logic [LVW-1:0] Q3   = LVW'(3 * LEVEL_WIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [7:0]           shifter, shifter_n, hold, hold_n;
    logic                 hold_full, hold_full_n, stop_sel, stop_sel_n;
    logic [LEN_WIDTH-1:0] bytes_left, bytes_left_n;
    logic [LVW-1:0]       lvl, lvl_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic                 line_n, done_n, underrun_n, last_lvl, xfer;

    assign byte_ready = (state == FETCH) | ((state == DATA) & ~hold_full & (bytes_left != '0));
    assign busy       = state != IDLE;
    assign xfer       = byte_valid & byte_ready;
    assign last_lvl   = lvl == LAST;

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state      <= IDLE;
            shifter    <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            stop_sel   <= 1'b0;
            bytes_left <= '0;
            lvl        <= '0;
            bit_cnt    <= '0;
            data_tx    <= 1'b1;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            shifter    <= shifter_n;
            hold       <= hold_n;
            hold_full  <= hold_full_n;
            stop_sel   <= stop_sel_n;
            bytes_left <= bytes_left_n;
            lvl        <= lvl_n;
            bit_cnt    <= bit_cnt_n;
            data_tx    <= line_n;
            done       <= done_n;
            underrun   <= underrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        shifter_n    = shifter;
        hold_n       = hold;
        hold_full_n  = hold_full;
        stop_sel_n   = stop_sel;
        bytes_left_n = bytes_left;
        lvl_n        = lvl;
        bit_cnt_n    = bit_cnt;
        done_n       = 1'b0;
        underrun_n   = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                stop_sel_n   = stop_mode;
                bytes_left_n = byte_count;
                lvl_n        = '0;
                bit_cnt_n    = '0;
                hold_full_n  = 1'b0;
                state_n      = (byte_count == '0) ? STOP : FETCH;
            end
            FETCH: if (xfer) begin
                shifter_n    = byte_data;
                bytes_left_n = bytes_left - LEN_WIDTH'(1);
                lvl_n        = '0;
                bit_cnt_n    = '0;
                state_n      = DATA;
            end
            DATA: begin
                lvl_n = last_lvl ? '0 : lvl + LVW'(1);
                if (xfer) begin
                    hold_n       = byte_data;
                    hold_full_n  = 1'b1;
                    bytes_left_n = bytes_left - LEN_WIDTH'(1);
                end
                if (last_lvl) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    shifter_n = {shifter[6:0], 1'b0};
                    if (bit_cnt == 3'd7) begin
                        // a byte arriving exactly at the byte boundary goes straight to the shifter
                        if (hold_full | xfer) begin
                            shifter_n   = hold_full ? hold : byte_data;
                            hold_full_n = 1'b0;
                        end else if (bytes_left == '0) begin
                            state_n = STOP;
                        end else begin
                            underrun_n = 1'b1;
                            state_n    = IDLE;
                        end
                    end
                end
            end
            STOP: begin
                lvl_n = last_lvl ? '0 : lvl + LVW'(1);
                if (last_lvl) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        endcase
        // data_tx is registered, so it is encoded from the next-cycle state
        line_n = (state_n == DATA) ? (lvl_n >= (shifter_n[7] ? Q1 : Q3)) :
                 (state_n == STOP) ? (lvl_n >= (stop_sel_n ? Q1 : Q2)) : 1'b1;
    end
endmodule

// File: tb/tb_joybus_frame_tx.sv
// tb_joybus_frame_tx: self-checking bench for joybus_frame_tx; the expected
// line waveform is built from per-bit level patterns of the payload bytes.
module tb_joybus_frame_tx;
    localparam int LW   = 2;
    localparam int BW   = 4 * LW;
    localparam int LENW = 6;
    // level patterns, bit q = level q of the symbol
    localparam logic [3:0] ZERO_PAT = 4'b1000;
    localparam logic [3:0] ONE_PAT  = 4'b1110;
    localparam logic [3:0] CTRL_PAT = 4'b1100;
    localparam logic [3:0] CONS_PAT = 4'b1110;

    logic            sample_clk = 1'b0;
    logic            reset, start, stop_mode, byte_valid;
    logic [LENW-1:0] byte_count;
    logic [7:0]      byte_data;
    logic            byte_ready, data_tx, busy, done, underrun;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] payload[$];
    logic       exp_q[$];
    int         idx, xfers, valid_pct;
    bit         feed_en;

    always #5 sample_clk = ~sample_clk;

    joybus_frame_tx #(.LEVEL_WIDTH(LW), .LEN_WIDTH(LENW)) dut (
        .sample_clk(sample_clk),
        .reset(reset),
        .start(start),
        .byte_count(byte_count),
        .stop_mode(stop_mode),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .data_tx(data_tx),
        .busy(busy),
        .done(done),
        .underrun(underrun)
    );

    // byte source: presents payload bytes in order with random valid gaps
    initial begin
        idx = 0;
        xfers = 0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        forever begin
            @(negedge sample_clk);
            if (byte_valid && byte_ready) begin
                xfers++;
                idx++;
            end
            @(posedge sample_clk);
            #2;
            byte_valid = feed_en && (idx < payload.size()) && ($urandom_range(1, 100) <= valid_pct);
            byte_data  = (idx < payload.size()) ? payload[idx] : 8'($urandom);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input int nbytes, input bit sm, input bit with_stop);
        logic [3:0] pat;
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            b = payload[i];
            for (int k = 7; k >= 0; k--) begin
                pat = b[k] ? ONE_PAT : ZERO_PAT;
                for (int l = 0; l < BW; l++) exp_q.push_back(pat[l / LW]);
            end
        end
        if (with_stop) begin
            pat = sm ? CONS_PAT : CTRL_PAT;
            for (int l = 0; l < BW; l++) exp_q.push_back(pat[l / LW]);
        end
    endtask

    task automatic do_start(input int cnt, input bit sm, input bit en);
        @(posedge sample_clk);
        #1;
        feed_en = en;
        idx = 0;
        xfers = 0;
        start = 1'b1;
        byte_count = cnt[LENW-1:0];
        stop_mode = sm;
        @(posedge sample_clk);
        #1;
        start = 1'b0;
        byte_count = LENW'($urandom);
        stop_mode = 1'($urandom);
    endtask

    // exp_delay: cycles from start to first low level (-1 = not checked)
    task automatic run_frame(input int cnt, input bit sm, input int exp_delay, input bit under,
                             input int hold, input int ign_at, input string tag);
        int waited;
        build_exp(under ? payload.size() : cnt, sm, !under);
        do_start(cnt, sm, hold == 0);
        @(negedge sample_clk);
        chk({tag, "_busy_after_start"}, busy, 1);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_stall_line"}, data_tx, 1);
            chk({tag, "_stall_ready"}, byte_ready, 1);
            @(negedge sample_clk);
        end
        feed_en = 1'b1;
        waited = 0;
        while (data_tx === 1'b1 && waited < 2000) begin
            waited++;
            @(negedge sample_clk);
        end
        chk({tag, "_first_low_seen"}, waited < 2000, 1);
        if (exp_delay >= 0) chk({tag, "_first_low_cycle"}, waited + 1, exp_delay);
        foreach (exp_q[j]) begin
            chk({tag, "_line"}, data_tx, exp_q[j]);
            chk({tag, "_busy"}, busy, 1);
            if (cnt == 0) chk({tag, "_ready_low"}, byte_ready, 0);
            if (ign_at > 0 && j == ign_at) begin
                start = 1'b1;
                byte_count = LENW'($urandom);
            end
            if (ign_at > 0 && j == ign_at + 1) start = 1'b0;
            @(negedge sample_clk);
        end
        chk({tag, "_end_line"}, data_tx, 1);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_done"}, done, !under);
        chk({tag, "_end_underrun"}, underrun, under);
        chk({tag, "_xfers"}, xfers, under ? payload.size() : cnt);
        @(negedge sample_clk);
        chk({tag, "_pulse_done_clear"}, done, 0);
        chk({tag, "_pulse_underrun_clear"}, underrun, 0);
        chk({tag, "_idle_line"}, data_tx, 1);
    endtask

    initial begin
        int waited;
        int cnt;
        reset = 1'b1;
        start = 1'b0;
        byte_count = '0;
        stop_mode = 1'b0;
        feed_en = 1'b0;
        valid_pct = 100;
        repeat (2) @(negedge sample_clk);
        reset = 1'b0;
        repeat (3) @(negedge sample_clk);
        reset = 1'b1;
        repeat (3) @(negedge sample_clk);
        chk("rst_data_tx", data_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        reset = 1'b0;
        @(negedge sample_clk);
        chk("post_rst_line", data_tx, 1);

        payload = {8'h05, 8'h00, 8'h00};
        run_frame(3, 1'b0, 2, 1'b0, 0, 0, "info");

        payload.delete();
        run_frame(0, 1'b1, 1, 1'b0, 0, 0, "zero_console");
        payload.delete();
        run_frame(0, 1'b0, 1, 1'b0, 0, 0, "zero_ctrl");

        payload = {8'hFF};
        run_frame(2, 1'b0, 2, 1'b1, 0, 0, "underrun");

        payload.delete();
        repeat (4) payload.push_back(8'($urandom));
        valid_pct = 70;
        run_frame(4, 1'b1, -1, 1'b0, 10, 40, "stall");

        payload.delete();
        repeat (63) payload.push_back(8'($urandom));
        valid_pct = 60;
        run_frame(63, 1'b0, -1, 1'b0, 0, 300, "max_len");

        for (int r = 0; r < 4; r++) begin
            cnt = $urandom_range(1, 8);
            payload.delete();
            repeat (cnt) payload.push_back(8'($urandom));
            valid_pct = $urandom_range(50, 100);
            run_frame(cnt, 1'($urandom), -1, 1'b0, 0, 30, "rand");
        end

        feed_en = 1'b0;
        valid_pct = 100;
        payload.delete();
        repeat (3) payload.push_back(8'($urandom));
        do_start(3, 1'b0, 1'b1);
        @(negedge sample_clk);
        waited = 0;
        while (data_tx === 1'b1 && waited < 2000) begin
            waited++;
            @(negedge sample_clk);
        end
        repeat (8 * BW + 3 * BW + 2) @(negedge sample_clk);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        feed_en = 1'b0;
        @(negedge sample_clk);
        reset = 1'b0;
        chk("mid_rst_line", data_tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", byte_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_underrun", underrun, 0);
        payload = {8'hA5};
        run_frame(1, 1'b0, 2, 1'b0, 0, 0, "post_rst_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/joybus_frame_tx.md
# joybus_frame_tx

Parametrised Joybus frame transmitter: serialises a variable-length byte stream onto the single-wire Joybus line using the 4-level bit encoding, then appends a selectable stop bit. Sits between response-building logic (INFO/STATUS/READ/WRITE handlers, CRC generator) and the open-drain line driver. It generalises the fixed-buffer N64 response transmitter with a streamed byte input, configurable level width and frame length, console- or controller-style stop bit, and underrun detection.

## Interface
Parameters:
- LEVEL_WIDTH, 2: sample_clk cycles per level; bit width BW = 4*LEVEL_WIDTH.
- LEN_WIDTH, 6: width of byte_count; max frame 2^LEN_WIDTH-1 bytes.

Ports (one clock, `sample_clk`; reset `reset` is synchronous, active-high):
- sample_clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin frame; sampled only in IDLE.
- byte_count  in  LEN_WIDTH  frame length in bytes, latched with start.
- stop_mode  in  1  latched with start; 0 = controller stop L,L,H,H; 1 = console stop L,H,H,H.
- byte_data  in  8  next payload byte, MSB sent first.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  block can accept a byte; transfer when valid & ready high in the same cycle.
- data_tx  out  1  registered line level; idle high.
- busy  out  1  high from cycle after accepted start until frame ends.
- done  out  1  one-cycle pulse after last stop level.
- underrun  out  1  one-cycle pulse on frame abort due to missing byte.

## Operation
- Encoding per bit, LEVEL_WIDTH cycles per level: 0 = L,L,L,H; 1 = L,H,H,H.
- Datapath: 8-bit shifter + 8-bit holding register (hold_full flag); bytes_left counter (LEN_WIDTH) of bytes not yet fetched; level counter 0..BW-1; bit counter 0..7.
- States:
  - IDLE: data_tx=1. On start: latch byte_count/stop_mode; count 0 -> STOP, else -> FETCH.
  - FETCH: byte_ready=1; waits indefinitely, line high. On transfer: byte into shifter, bytes_left--, -> DATA.
  - DATA: drive encoded levels of shifter MSB. byte_ready = ~hold_full & (bytes_left != 0). At last level of bit 7: if bytes_left==0 and hold empty -> STOP; if hold_full -> hold into shifter, continue; else -> pulse underrun, -> IDLE (no stop bit).
  - STOP: BW cycles of selected stop pattern, then data_tx=1, done pulse, -> IDLE.
- A transfer in the same cycle the hold moves into the shifter is not possible (ready low while full); no byte lost.
- start while busy ignored; byte_valid with ready low ignored.
- bytes_left never wraps: decrement only when nonzero.

## Timing
- Reset values: data_tx=1, busy=0, byte_ready=0, done=0, underrun=0, hold empty, state IDLE.
- Reset mid-frame: next cycle all outputs at reset values; no done/underrun pulse; partial frame discarded.
- start at cycle T -> FETCH at T+1 (busy=1, byte_ready=1). Byte transferred at cycle F -> first level on data_tx at F+1.
- Frame on line: count*8*BW + BW cycles, contiguous, no gaps between bits/bytes.
- done and busy=0 in the cycle after last stop level; data_tx=1 that cycle; new start accepted that cycle.
- Underrun: detected at last level of a bit 7; underrun pulse, busy=0, data_tx=1 in next cycle.
- count=0: STOP at T+1, stop pattern on cycles T+1..T+BW, done at T+BW+1.

## Test plan
- Reset: assert reset 3 cycles mid-idle -> data_tx=1, busy=0, byte_ready=0, done=0, underrun=0.
- INFO frame, LEVEL_WIDTH=2: start at cycle 0, count=3, bytes 0x05,0x00,0x00 with valid held high, stop_mode=0 -> first 8 line cycles 0,0,0,0,0,0,1,1; line active cycles 2..201 (200 cycles), last 8 = 0,0,0,0,1,1,1,1; done at 202, exactly 3 transfers.
- Zero-length console stop: count=0, stop_mode=1 -> line 0,0,1,1,1,1,1,1 then done; byte_ready never high.
- Underrun: count=2, byte 0xFF, byte_valid then low -> 64 cycles of L,H,H,H pattern, then underrun pulse, data_tx=1, busy=0, no stop bit, no done.
- Backpressure/ignore: hold byte_valid low 10 cycles in FETCH -> line stays high, then frame proceeds normally; start pulses while busy -> no effect; count=63 -> exactly 63 transfers, no wrap.
- Reset mid-frame at byte 1 bit 3 -> idle next cycle; immediate new start count=1 byte 0xA5 -> correct 1-byte frame and done.
